// File: rtl/top.sv
// Acquisition controller: captures NSAMPLE ADC words into a sample RAM, serialises them
// on request, and streams the latest captured sample as 16-bit frames to two DAC channels.
module top #(
  parameter int ADCDATA  = 12,
  parameter int DACDATA  = 12,
  parameter int NSAMPLE  = 10,
  parameter int ADDRSIZE = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_acq,
  input  logic               RAM_enr,
  output logic               RAM_datao,
  input  logic [ADCDATA-1:0] ADC_data,
  output logic               DAC_mosi1,
  output logic               DAC_mosi2
);

  localparam logic [3:0]          DAC_CMD   = 4'b0011;
  localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(NSAMPLE - 1);
  localparam logic [ADDRSIZE-1:0] ADDR_ZERO = ADDRSIZE'(0);
  localparam logic [ADDRSIZE-1:0] ADDR_ONE  = ADDRSIZE'(1);
  localparam logic [3:0]          MSB_BIT   = 4'(ADCDATA - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic                en_prev_r, rd_prev_r;
  logic                en_rise_s, rd_rise_s;
  logic [ADDRSIZE-1:0] addr_r, addr_nxt_s;
  logic [ADDRSIZE-1:0] rd_word_r, rd_word_nxt_s;
  logic [3:0]          rd_bit_r, rd_bit_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic                datao_r, datao_nxt_s;
  logic                we_s;
  logic [ADCDATA-1:0]  ram_r [0:(1 << ADDRSIZE)-1];
  logic [ADCDATA-1:0]  ram_rd_s;
  logic [ADCDATA-1:0]  last_sample_r;
  logic [3:0]          cnt_r;
  logic [DACDATA-1:0]  dac_data_r;
  logic                mosi1_r, mosi2_r;

  // Frame position 0..3 carries the command nibble, 4..15 the data word, MSB first.
  function automatic logic frame_bit(input logic [3:0] pos, input logic [DACDATA-1:0] data);
    logic b;
    if (pos < 4'd4) begin
      b = DAC_CMD[2'd3 - pos[1:0]];
    end else begin
      b = data[4'd15 - pos];
    end
    return b;
  endfunction

  assign en_rise_s = en_acq & ~en_prev_r;
  assign rd_rise_s = RAM_enr & ~rd_prev_r;
  assign ram_rd_s  = ram_r[rd_word_r];

  // Next-state and datapath control; acquisition always wins over readout.
  always_comb begin
    state_nxt_s   = state_r;
    addr_nxt_s    = addr_r;
    rd_word_nxt_s = rd_word_r;
    rd_bit_nxt_s  = rd_bit_r;
    valid_nxt_s   = valid_r;
    datao_nxt_s   = 1'b0;
    we_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (en_rise_s) begin
          state_nxt_s = ST_ACQ;
          addr_nxt_s  = ADDR_ZERO;
        end else if (rd_rise_s) begin
          state_nxt_s   = ST_READ;
          rd_word_nxt_s = ADDR_ZERO;
          rd_bit_nxt_s  = MSB_BIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACQ: begin
        we_s = 1'b1;
        if (addr_r == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
          valid_nxt_s = 1'b1;
        end else begin
          addr_nxt_s = addr_r + ADDR_ONE;
        end
      end
      ST_READ: begin
        if (en_rise_s) begin
          state_nxt_s = ST_ACQ;
          addr_nxt_s  = ADDR_ZERO;
        end else if (!RAM_enr) begin
          state_nxt_s = ST_IDLE;
        end else begin
          datao_nxt_s = valid_r & ram_rd_s[rd_bit_r];
          if (rd_bit_r == 4'd0) begin
            if (rd_word_r == LAST_ADDR) begin
              state_nxt_s = ST_IDLE;
            end else begin
              rd_word_nxt_s = rd_word_r + ADDR_ONE;
              rd_bit_nxt_s  = MSB_BIT;
            end
          end else begin
            rd_bit_nxt_s = rd_bit_r - 4'd1;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Control state, counters, edge detectors and the serial readout register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      en_prev_r     <= 1'b0;
      rd_prev_r     <= 1'b0;
      addr_r        <= ADDR_ZERO;
      rd_word_r     <= ADDR_ZERO;
      rd_bit_r      <= 4'd0;
      valid_r       <= 1'b0;
      datao_r       <= 1'b0;
      last_sample_r <= {ADCDATA{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      en_prev_r <= en_acq;
      rd_prev_r <= RAM_enr;
      addr_r    <= addr_nxt_s;
      rd_word_r <= rd_word_nxt_s;
      rd_bit_r  <= rd_bit_nxt_s;
      valid_r   <= valid_nxt_s;
      datao_r   <= datao_nxt_s;
      if (we_s) begin
        last_sample_r <= ADC_data;
      end
    end
  end

  // Sample storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      ram_r[addr_r] <= ADC_data;
    end
  end

  // Free-running DAC framer; data is latched at frame start so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= 4'd0;
      dac_data_r <= {DACDATA{1'b0}};
      mosi1_r    <= 1'b0;
      mosi2_r    <= 1'b0;
    end else begin
      cnt_r   <= cnt_r + 4'd1;
      mosi1_r <= frame_bit(cnt_r, dac_data_r);
      mosi2_r <= frame_bit(cnt_r, ~dac_data_r);
      if (cnt_r == 4'd0) begin
        dac_data_r <= DACDATA'(last_sample_r);
      end
    end
  end

  assign RAM_datao = datao_r;
  assign DAC_mosi1 = mosi1_r;
  assign DAC_mosi2 = mosi2_r;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: random ADC data and request timing checked every cycle
// against a behavioural model of captures, readouts and DAC frames.
module tb_top;

  localparam int NS = 10;

  logic        clk;
  logic        reset;
  logic        en_acq;
  logic        RAM_enr;
  logic        RAM_datao;
  logic [11:0] ADC_data;
  logic        DAC_mosi1;
  logic        DAC_mosi2;

  int n_cmp = 0;
  int n_err = 0;

  int m_ram [0:127];
  bit m_en_prev, m_rd_prev, m_valid, m_rd_active;
  int m_acq_left, m_rd_idx, m_last, m_frame, m_edges;
  bit exp_datao, exp_m1, exp_m2;
  int adc_fixed = -1;
  logic [15:0] v1, v2;

  top #(.ADCDATA(12), .DACDATA(12), .NSAMPLE(NS), .ADDRSIZE(7)) dut (
    .clk(clk), .reset(reset), .en_acq(en_acq), .RAM_enr(RAM_enr), .RAM_datao(RAM_datao),
    .ADC_data(ADC_data), .DAC_mosi1(DAC_mosi1), .DAC_mosi2(DAC_mosi2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit fbit(int pos, int data);
    if (pos < 4) return bit'((3 >> (3 - pos)) & 1);
    return bit'((data >> (15 - pos)) & 1);
  endfunction

  task automatic check(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check16(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%04h expected=%04h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en_prev = 1'b0; m_rd_prev = 1'b0; m_valid = 1'b0; m_rd_active = 1'b0;
    m_acq_left = 0; m_rd_idx = 0; m_last = 0; m_frame = 0; m_edges = 0;
    exp_datao = 1'b0; exp_m1 = 1'b0; exp_m2 = 1'b0;
  endtask

  // What the outputs should show after one rising edge, given the inputs seen at it.
  task automatic model_edge();
    bit en_rise, rd_rise;
    int pos;
    if (reset) begin
      model_reset();
      return;
    end
    en_rise = en_acq && !m_en_prev;
    rd_rise = RAM_enr && !m_rd_prev;
    pos = m_edges % 16;
    if (pos == 0) m_frame = m_last;
    exp_m1 = fbit(pos, m_frame);
    exp_m2 = fbit(pos, 4095 - m_frame);
    m_edges++;
    exp_datao = 1'b0;
    if (m_acq_left > 0) begin
      m_ram[NS - m_acq_left] = int'(ADC_data);
      m_last = int'(ADC_data);
      m_acq_left--;
      if (m_acq_left == 0) m_valid = 1'b1;
    end else if (en_rise) begin
      m_acq_left = NS;
      m_rd_active = 1'b0;
    end else if (m_rd_active) begin
      if (!RAM_enr) begin
        m_rd_active = 1'b0;
      end else begin
        if (m_valid) exp_datao = bit'((m_ram[m_rd_idx / 12] >> (11 - m_rd_idx % 12)) & 1);
        m_rd_idx++;
        if (m_rd_idx == NS * 12) m_rd_active = 1'b0;
      end
    end else if (rd_rise) begin
      m_rd_active = 1'b1;
      m_rd_idx = 0;
    end
    m_en_prev = en_acq;
    m_rd_prev = RAM_enr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("RAM_datao", RAM_datao, exp_datao);
    check("DAC_mosi1", DAC_mosi1, exp_m1);
    check("DAC_mosi2", DAC_mosi2, exp_m2);
    ADC_data = (adc_fixed >= 0) ? 12'(adc_fixed) : 12'($urandom_range(0, 4095));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b0; en_acq = 1'b0; RAM_enr = 1'b0; ADC_data = 12'd0;
    for (int i = 0; i < 128; i++) m_ram[i] = 0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("reset_datao", RAM_datao, 1'b0);
    check("reset_mosi1", DAC_mosi1, 1'b0);
    check("reset_mosi2", DAC_mosi2, 1'b0);
    run(3);
    reset = 1'b0;
    run(4);

    // Readout before any acquisition: all zeros.
    RAM_enr = 1'b1; run(125); RAM_enr = 1'b0; run(3);

    // Plain acquisition then a full readout.
    en_acq = 1'b1; run(3); en_acq = 1'b0; run(14);
    RAM_enr = 1'b1; run(125); RAM_enr = 1'b0; run(3);

    // en_acq held with a re-pulse mid-capture: a single capture.
    en_acq = 1'b1; run(3); en_acq = 1'b0; run(1); en_acq = 1'b1; run(16); en_acq = 1'b0; run(2);
    RAM_enr = 1'b1; run(125); RAM_enr = 1'b0; run(3);

    // Capture ending in 0x0F0, then inspect the next complete DAC frame.
    adc_fixed = 12'h0F0; ADC_data = 12'h0F0;
    en_acq = 1'b1; run(1); en_acq = 1'b0; run(11);
    adc_fixed = -1;
    for (int i = 0; i < 16 && (m_edges % 16) != 0; i++) tick();
    v1 = 16'd0; v2 = 16'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      v1 = {v1[14:0], DAC_mosi1};
      v2 = {v2[14:0], DAC_mosi2};
    end
    check16("dac1_frame", v1, 16'h30F0);
    check16("dac2_frame", v2, 16'h3F0F);

    // Readout abort after 30 bits, then a full restart.
    RAM_enr = 1'b1; run(31); RAM_enr = 1'b0; run(2);
    RAM_enr = 1'b1; run(125); RAM_enr = 1'b0; run(2);

    // en_acq rising during a readout takes over.
    RAM_enr = 1'b1; run(20); en_acq = 1'b1; run(1); en_acq = 1'b0; run(12);
    RAM_enr = 1'b0; run(2);
    RAM_enr = 1'b1; run(125); RAM_enr = 1'b0; run(2);

    // Simultaneous rises, and a readout request during capture: both ignored.
    en_acq = 1'b1; RAM_enr = 1'b1; run(12); en_acq = 1'b0; run(5); RAM_enr = 1'b0; run(2);
    en_acq = 1'b1; run(3); RAM_enr = 1'b1; run(15); RAM_enr = 1'b0; en_acq = 1'b0; run(2);

    // Asynchronous reset at the fourth sample of an acquisition.
    en_acq = 1'b1; run(5); en_acq = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_datao", RAM_datao, 1'b0);
    check("async_mosi1", DAC_mosi1, 1'b0);
    check("async_mosi2", DAC_mosi2, 1'b0);
    model_reset();
    @(negedge clk);
    run(3);
    reset = 1'b0;
    run(20);
    RAM_enr = 1'b1; run(125); RAM_enr = 1'b0; run(2);

    // Random request timing.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) en_acq = ~en_acq;
      if ($urandom_range(0, 39) == 0) RAM_enr = ~RAM_enr;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameters: ADCDATA = 12 (ADC word width); DACDATA = 12 (DAC word width); NSAMPLE = 10 (samples per acquisition); ADDRSIZE = 7 (sample-RAM address width, 128 words).
REQ-002 The port list SHALL be, in order:
- clk — input, 1 bit. The only clock; all logic runs on its rising edge.
- reset — input, 1 bit. Asynchronous, active-high reset.
- en_acq — input, 1 bit. Acquisition request; its rising edge starts an acquisition.
- RAM_enr — input, 1 bit. Readout request; its rising edge starts a serial dump of the RAM.
- RAM_datao — output, 1 bit. Serial RAM readout data.
- ADC_data — input, ADCDATA bits. Parallel ADC sample.
- DAC_mosi1 — output, 1 bit. Serial DAC channel 1 data.
- DAC_mosi2 — output, 1 bit. Serial DAC channel 2 data.
REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 Detect rising edges by registering en_acq and RAM_enr:
- an edge is present when the input is 1 and its registered copy is 0;
- the edge is recognised at edge k.
REQ-005 Acquisition start: an en_acq rise at edge k SHALL capture ADC_data at edges k+1 … k+NSAMPLE into RAM addresses 0 … NSAMPLE-1.
REQ-006 Capture rate is one sample per clock; addresses are written in increasing order.
REQ-007 Each acquisition SHALL always restart at address 0; addresses NSAMPLE … 127 are never written.
REQ-008 A new en_acq rise during an acquisition SHALL be ignored.
- en_acq held high SHALL NOT retrigger.
- en_acq falling mid-acquisition SHALL NOT abort it.
REQ-009 After the first completed acquisition, an internal valid flag SHALL be set; reset clears it.
REQ-010 Readout start: a RAM_enr rise at edge r, with no acquisition active, starts a readout.
- Serialise words 0 … NSAMPLE-1, MSB first, one bit per clock.
- RAM_datao carries bit 11 of word 0 after edge r+1 and bit 0 of word 9 after edge r+120.
- RAM_datao returns to 0 after edge r+121.
REQ-011 Readout with valid flag clear SHALL output all zeros for the full 120-bit duration.
REQ-012 Readout abort: RAM_enr dropping to 0 mid-readout SHALL abort it.
- RAM_datao = 0 from the next edge.
- A later RAM_enr rise restarts from word 0, bit 11.
REQ-013 Simultaneous rises, and en_acq rising during a readout: acquisition has priority.
- Any readout is aborted and RAM_datao = 0.
- A RAM_enr rise during an acquisition SHALL be ignored.
REQ-014 When idle, RAM_datao SHALL be 0.
REQ-015 DAC framing: a free-running 4-bit frame counter (0 … 15, wraps) SHALL define continuous 16-bit frames on both DAC outputs.
- Bits 0–3: command 4'b0011, MSB first.
- Bits 4–15: 12-bit data, MSB first.
- The counter starts at 0 after reset.
REQ-016 DAC data latching: at counter = 0, the frame data SHALL be latched.
- DAC_mosi1 data = the most recently captured ADC sample (reset value 0).
- DAC_mosi2 data = its bitwise complement (4095 − sample).
- A sample captured mid-frame appears only in the next frame.
REQ-017 All outputs SHALL be registered.
- The bit for counter value n is driven after the edge on which the counter equals n.

Reset
REQ-018 While reset is high, all of the following SHALL be 0 immediately and held:
- RAM_datao, DAC_mosi1, DAC_mosi2;
- edge-detect registers, frame counter, address/bit counters;
- valid flag, latched DAC data.
REQ-019 RAM array contents SHALL NOT be reset.
REQ-020 Reset asserted mid-acquisition or mid-readout SHALL abandon the operation.
- After reset release, no operation starts until a fresh rising edge of en_acq or RAM_enr.

Verification
REQ-021 Acquire/readout: ADC_data = cycle index n at edge n; en_acq rises at edge 5 → RAM[0..9] = 6 … 15. A RAM_enr pulse then gives RAM_datao = 120 bits 0x006 … 0x00F, MSB first, then 0.
REQ-022 Readout before any acquisition after reset → RAM_datao stays 0 for the entire readout window.
REQ-023 en_acq held high 20 cycles, pulsed again at cycle 3 of the capture → exactly one capture of 10 samples; RAM[10] is untouched.
REQ-024 After a capture with last sample 0x0F0 → next DAC_mosi1 frame = 0011 0000 1111 0000; DAC_mosi2 frame = 0011 1111 0000 1111.
REQ-025 Abort/priority:
- RAM_enr dropped after 30 readout bits → RAM_datao = 0 next cycle; a re-pulse restarts at word 0, bit 11.
- en_acq rising during readout → readout aborted and a capture performed.
REQ-026 Reset asserted at sample 4 of an acquisition → all outputs 0 asynchronously; after release, no capture continues and the valid flag is 0.
